// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-side signal bundle for alu_arbiter.
// slave = arbiter view; master = requesters plus the ALU.
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [4:0]       req0_shamt;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [4:0]       req1_shamt;

    logic             rsp0_valid;
    logic [WIDTH-1:0] rsp0_data;
    logic             rsp0_zero;
    logic             rsp1_valid;
    logic [WIDTH-1:0] rsp1_data;
    logic             rsp1_zero;

    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic [2:0]       alu_op;
    logic [4:0]       alu_shamt;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;

    logic             busy;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_shamt,
        input  req1_valid, req1_op, req1_a, req1_b, req1_shamt,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp0_zero,
        output rsp1_valid, rsp1_data, rsp1_zero,
        output alu_in1, alu_in2, alu_op, alu_shamt,
        input  alu_out, alu_zero,
        output busy
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_shamt,
        output req1_valid, req1_op, req1_a, req1_b, req1_shamt,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp0_zero,
        input  rsp1_valid, rsp1_data, rsp1_zero,
        input  alu_in1, alu_in2, alu_op, alu_shamt,
        output alu_out, alu_zero,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared registered ALU.
// One op in flight: accept -> ISSUE -> RESP, with a fresh accept allowed during RESP.
module alu_arbiter #(
    parameter bit          RR_EN = 1'b1,
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } state_e;

    localparam logic [2:0] OpBranch = 3'd6;

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_last_grant;
    logic             r_port;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [4:0]       r_shamt;

    logic             w_accept_ok;
    logic             w_gnt_valid;
    logic             w_gnt_port;
    logic             w_rsp_fire;
    logic             w_rsp0_sel;
    logic             w_rsp1_sel;
    logic [WIDTH-1:0] w_rsp_data;

    // rst_n gates acceptance so ready reads 0 for the whole reset window.
    assign w_accept_ok = rst_n && ((r_state == StIdle) || (r_state == StResp));

    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_port  = 1'b0;
        if (w_accept_ok) begin
            unique case ({bus.req1_valid, bus.req0_valid})
                2'b01: begin
                    w_gnt_valid = 1'b1;
                    w_gnt_port  = 1'b0;
                end
                2'b10: begin
                    w_gnt_valid = 1'b1;
                    w_gnt_port  = 1'b1;
                end
                2'b11: begin
                    w_gnt_valid = 1'b1;
                    w_gnt_port  = RR_EN ? ~r_last_grant : 1'b0;
                end
                default: begin
                    w_gnt_valid = 1'b0;
                    w_gnt_port  = 1'b0;
                end
            endcase
        end
    end

    assign bus.req0_ready = w_gnt_valid & ~w_gnt_port;
    assign bus.req1_ready = w_gnt_valid &  w_gnt_port;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  w_state_nxt = w_gnt_valid ? StIssue : StIdle;
            StIssue: w_state_nxt = StResp;
            StResp:  w_state_nxt = w_gnt_valid ? StIssue : StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holding registers double as the ALU input drivers: they only change on the
    // accept edge, so the ALU sees stable operands outside ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_port       <= 1'b0;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_shamt      <= '0;
        end else if (w_gnt_valid) begin
            r_last_grant <= w_gnt_port;
            r_port       <= w_gnt_port;
            r_op         <= w_gnt_port ? bus.req1_op    : bus.req0_op;
            r_a          <= w_gnt_port ? bus.req1_a     : bus.req0_a;
            r_b          <= w_gnt_port ? bus.req1_b     : bus.req0_b;
            r_shamt      <= w_gnt_port ? bus.req1_shamt : bus.req0_shamt;
        end
    end

    assign bus.alu_in1   = r_a;
    assign bus.alu_in2   = r_b;
    assign bus.alu_op    = r_op;
    assign bus.alu_shamt = r_shamt;

    // r_op still holds the in-flight op during RESP; a new accept lands on the next edge.
    assign w_rsp_fire = (r_state == StResp);
    assign w_rsp0_sel = w_rsp_fire & ~r_port;
    assign w_rsp1_sel = w_rsp_fire &  r_port;
    assign w_rsp_data = (r_op == OpBranch) ? '0 : bus.alu_out;

    assign bus.rsp0_valid = w_rsp0_sel;
    assign bus.rsp0_data  = w_rsp0_sel ? w_rsp_data : '0;
    assign bus.rsp0_zero  = w_rsp0_sel & bus.alu_zero;
    assign bus.rsp1_valid = w_rsp1_sel;
    assign bus.rsp1_data  = w_rsp1_sel ? w_rsp_data : '0;
    assign bus.rsp1_zero  = w_rsp1_sel & bus.alu_zero;

    assign bus.busy = (r_state != StIdle);
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: RR_EN=1 and RR_EN=0 instances, each with a
// registered ALU model, and a per-port scoreboard of expected responses.
module tb_alu_arbiter;
    localparam int unsigned WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             zero;
        int               cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter_if #(.WIDTH(WIDTH)) ifa ();
    alu_arbiter_if #(.WIDTH(WIDTH)) ifb ();

    alu_arbiter #(.RR_EN(1'b1), .WIDTH(WIDTH)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    alu_arbiter #(.RR_EN(1'b0), .WIDTH(WIDTH)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b, input logic [4:0] sh);
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a << sh;
            3'd5: r = a >> sh;
            3'd6: r = a - b;
            default: r[0] = ($signed(a) < $signed(b));
        endcase
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b, input logic [4:0] sh, input int c);
        exp_t e;
        e.data = (op == 3'd6) ? '0 : alu_f(op, a, b, sh);
        e.zero = (a == b);
        e.cyc  = c;
        return e;
    endfunction

    // Registered ALU models.
    always @(posedge clk) begin
        ifa.alu_out  <= alu_f(ifa.alu_op, ifa.alu_in1, ifa.alu_in2, ifa.alu_shamt);
        ifa.alu_zero <= (ifa.alu_in1 == ifa.alu_in2);
        ifb.alu_out  <= alu_f(ifb.alu_op, ifb.alu_in1, ifb.alu_in2, ifb.alu_shamt);
        ifb.alu_zero <= (ifb.alu_in1 == ifb.alu_in2);
    end

    exp_t             q0[$];
    exp_t             q1[$];
    int               grant_log[$];
    int               rsp_seq_cyc[$];
    logic [WIDTH-1:0] rsp_seq_data[$];
    int               rsp_cnt0 = 0;
    int               rsp_cnt1 = 0;
    logic [WIDTH-1:0] last0_data, last1_data;
    logic             last0_zero, last1_zero;
    int               last0_cyc, last1_cyc;
    int               bg_log[$];
    int               bg_cyc[$];
    int               hs_cyc;

    // Scoreboard for instance A: responses are popped before this cycle's accepts are pushed.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            chk("one_ready_a", 64'(ifa.req0_ready & ifa.req1_ready), 64'd0);
            if (ifa.rsp0_valid) begin
                rsp_cnt0++;
                last0_data = ifa.rsp0_data;
                last0_zero = ifa.rsp0_zero;
                last0_cyc  = cyc;
                rsp_seq_data.push_back(ifa.rsp0_data);
                rsp_seq_cyc.push_back(cyc);
                chk("rsp0_pending", 64'(q0.size()), 64'd1);
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    chk("rsp0_data", 64'(ifa.rsp0_data), 64'(e.data));
                    chk("rsp0_zero", 64'(ifa.rsp0_zero), 64'(e.zero));
                    chk("rsp0_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                chk("rsp0_idle", 64'({ifa.rsp0_data, ifa.rsp0_zero}), 64'd0);
            end
            if (ifa.rsp1_valid) begin
                rsp_cnt1++;
                last1_data = ifa.rsp1_data;
                last1_zero = ifa.rsp1_zero;
                last1_cyc  = cyc;
                rsp_seq_data.push_back(ifa.rsp1_data);
                rsp_seq_cyc.push_back(cyc);
                chk("rsp1_pending", 64'(q1.size()), 64'd1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    chk("rsp1_data", 64'(ifa.rsp1_data), 64'(e.data));
                    chk("rsp1_zero", 64'(ifa.rsp1_zero), 64'(e.zero));
                    chk("rsp1_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                chk("rsp1_idle", 64'({ifa.rsp1_data, ifa.rsp1_zero}), 64'd0);
            end
            if (ifa.req0_valid && ifa.req0_ready) begin
                q0.push_back(mk_exp(ifa.req0_op, ifa.req0_a, ifa.req0_b, ifa.req0_shamt, cyc + 2));
                grant_log.push_back(0);
            end
            if (ifa.req1_valid && ifa.req1_ready) begin
                q1.push_back(mk_exp(ifa.req1_op, ifa.req1_a, ifa.req1_b, ifa.req1_shamt, cyc + 2));
                grant_log.push_back(1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (ifb.req0_valid && ifb.req0_ready) begin
                bg_log.push_back(0);
                bg_cyc.push_back(cyc);
            end
            if (ifb.req1_valid && ifb.req1_ready) begin
                bg_log.push_back(1);
                bg_cyc.push_back(cyc);
            end
        end
    end

    task automatic drive_a(input bit port, input logic v, input logic [2:0] op,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [4:0] sh);
        if (port == 1'b0) begin
            ifa.req0_valid = v; ifa.req0_op = op; ifa.req0_a = a; ifa.req0_b = b;
            ifa.req0_shamt = sh;
        end else begin
            ifa.req1_valid = v; ifa.req1_op = op; ifa.req1_a = a; ifa.req1_b = b;
            ifa.req1_shamt = sh;
        end
    endtask

    task automatic send_a(input bit port, input logic [2:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [4:0] sh);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        drive_a(port, 1'b1, op, a, b, sh);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port ? ifa.req1_ready : ifa.req0_ready) begin
                ok = 1'b1;
                hs_cyc = cyc;
                break;
            end
        end
        chk("send_handshake", 64'(ok), 64'd1);
        @(posedge clk); #1;
        drive_a(port, 1'b0, op, a, b, sh);
    endtask

    task automatic wait_quiet_a();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            if (!ifa.busy && q0.size() == 0 && q1.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("quiet_a", 64'(done), 64'd1);
    endtask

    initial begin
        int base;
        int rbase;
        int cnt0;
        bit hit;

        rst_n = 1'b0;
        drive_a(1'b0, 1'b1, 3'd0, '0, '0, '0);
        drive_a(1'b1, 1'b0, 3'd0, '0, '0, '0);
        ifb.req0_valid = 1'b0; ifb.req0_op = '0; ifb.req0_a = '0; ifb.req0_b = '0;
        ifb.req0_shamt = '0;
        ifb.req1_valid = 1'b0; ifb.req1_op = '0; ifb.req1_a = '0; ifb.req1_b = '0;
        ifb.req1_shamt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready0", 64'(ifa.req0_ready), 64'd0);
        chk("rst_busy", 64'(ifa.busy), 64'd0);
        chk("rst_rsp_valid", 64'({ifa.rsp0_valid, ifa.rsp1_valid}), 64'd0);
        chk("rst_alu_in", 64'({ifa.alu_in1, ifa.alu_op, ifa.alu_shamt}), 64'd0);
        drive_a(1'b0, 1'b0, 3'd0, '0, '0, '0);
        rst_n = 1'b1;

        // Single op, latency N -> N+2, no response on the other port.
        cnt0 = rsp_cnt1;
        send_a(1'b0, 3'd0, 32'd5, 32'd7, 5'd0);
        wait_quiet_a();
        chk("single_data", 64'(last0_data), 64'd12);
        chk("single_zero", 64'(last0_zero), 64'd0);
        chk("single_latency", 64'(last0_cyc - hs_cyc), 64'd2);
        chk("single_no_rsp1", 64'(rsp_cnt1), 64'(cnt0));

        // Wrap-around add and signed compare.
        send_a(1'b0, 3'd0, 32'hFFFF_FFFF, 32'd1, 5'd0);
        wait_quiet_a();
        chk("wrap_data", 64'(last0_data), 64'd0);
        send_a(1'b0, 3'd7, 32'd2, 32'd9, 5'd0);
        wait_quiet_a();
        chk("slt_data", 64'(last0_data), 64'd1);

        // Branch compare: data forced to 0, zero flag from the ALU.
        send_a(1'b1, 3'd6, 32'h1234, 32'h1234, 5'd0);
        wait_quiet_a();
        chk("br_eq_data", 64'(last1_data), 64'd0);
        chk("br_eq_zero", 64'(last1_zero), 64'd1);
        send_a(1'b1, 3'd6, 32'h1234, 32'h1235, 5'd0);
        wait_quiet_a();
        chk("br_ne_data", 64'(last1_data), 64'd0);
        chk("br_ne_zero", 64'(last1_zero), 64'd0);

        // Reset during ISSUE drops the op.
        cnt0 = rsp_cnt0;
        send_a(1'b0, 3'd0, 32'd5, 32'd7, 5'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(ifa.busy), 64'd0);
        chk("midrst_rsp_valid", 64'({ifa.rsp0_valid, ifa.rsp1_valid}), 64'd0);
        chk("midrst_alu_in1", 64'(ifa.alu_in1), 64'd0);
        chk("midrst_alu_in2", 64'(ifa.alu_in2), 64'd0);
        chk("midrst_alu_shamt", 64'(ifa.alu_shamt), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_no_rsp", 64'(rsp_cnt0), 64'(cnt0));
        chk("midrst_idle", 64'(ifa.busy), 64'd0);

        // Round-robin tie from fresh reset: grants 0,1,0,1, responses every 2 cycles.
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base  = grant_log.size();
        rbase = rsp_seq_data.size();
        @(posedge clk); #1;
        drive_a(1'b0, 1'b1, 3'd1, 32'd10, 32'd3, 5'd0);
        drive_a(1'b1, 1'b1, 3'd4, 32'd1, 32'd0, 5'd4);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (grant_log.size() - base >= 4) break;
        end
        @(posedge clk); #1;
        drive_a(1'b0, 1'b0, 3'd1, 32'd10, 32'd3, 5'd0);
        drive_a(1'b1, 1'b0, 3'd4, 32'd1, 32'd0, 5'd4);
        wait_quiet_a();
        chk("rr_grant_count", 64'(grant_log.size() - base), 64'd4);
        chk("rr_rsp_count", 64'(rsp_seq_data.size() - rbase), 64'd4);
        if (grant_log.size() - base >= 4 && rsp_seq_data.size() - rbase >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rr_grant%0d", i), 64'(grant_log[base+i]), 64'(i % 2));
                chk($sformatf("rr_data%0d", i), 64'(rsp_seq_data[rbase+i]),
                    (i % 2 == 1) ? 64'd16 : 64'd7);
                chk($sformatf("rr_spacing%0d", i),
                    64'(rsp_seq_cyc[rbase+i] - rsp_seq_cyc[rbase]), 64'(2 * i));
            end
        end

        // Fixed priority on instance B: port 1 starves until port 0 drops valid.
        @(posedge clk); #1;
        ifb.req0_valid = 1'b1; ifb.req0_op = 3'd0; ifb.req0_a = 32'd1; ifb.req0_b = 32'd2;
        ifb.req1_valid = 1'b1; ifb.req1_op = 3'd0; ifb.req1_a = 32'd3; ifb.req1_b = 32'd4;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (bg_log.size() >= 3) break;
        end
        @(posedge clk); #1 ifb.req0_valid = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (bg_log.size() >= 4) begin
                hit = 1'b1;
                break;
            end
        end
        @(posedge clk); #1 ifb.req1_valid = 1'b0;
        chk("fp_port1_served", 64'(hit), 64'd1);
        chk("fp_grant_count", 64'(bg_log.size()), 64'd4);
        if (bg_log.size() >= 4) begin
            for (int i = 0; i < 3; i++) chk($sformatf("fp_grant%0d", i), 64'(bg_log[i]), 64'd0);
            chk("fp_grant3", 64'(bg_log[3]), 64'd1);
            chk("fp_p1_first_accept", 64'(bg_cyc[3] - bg_cyc[2]), 64'd2);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("end_q0_empty", 64'(q0.size()), 64'd0);
        chk("end_q1_empty", 64'(q1.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single registered ALU between two independent requesters: port 0 is the main datapath and port 1 is the secondary (branch/address) unit.
- Accepts one operation at a time over a valid/ready handshake and drives the ALU operand, opcode and shamt inputs.
- Captures the ALU result one clock after issue and returns it to the granted requester as a one-cycle response pulse.
- Sits between the requesters and the ALU; it is the only driver of the ALU inputs.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration between ports; 0 = fixed priority, port 0 always wins.
- WIDTH, 32, operand and result width; must match the ALU.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_op  in  3  port 0 ALUOP.
- req0_a  in  WIDTH  port 0 operand 1.
- req0_b  in  WIDTH  port 0 operand 2.
- req0_shamt  in  5  port 0 shift amount.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_shamt: same as port 0, for port 1.
- rsp0_valid  out  1  port 0 result valid, one-cycle pulse.
- rsp0_data  out  WIDTH  port 0 result.
- rsp0_zero  out  1  port 0 equality flag (In1==In2).
- rsp1_valid, rsp1_data, rsp1_zero: same as port 0, for port 1.
- alu_in1  out  WIDTH  to ALU In1.
- alu_in2  out  WIDTH  to ALU In2.
- alu_op  out  3  to ALU ALUOP.
- alu_shamt  out  5  to ALU shamt.
- alu_out  in  WIDTH  from ALU OUT (registered in the ALU).
- alu_zero  in  1  from ALU ZeroFlag (registered in the ALU).
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, ISSUE, RESP. Reset value: IDLE.
- Reset values: all ready/rsp_valid outputs 0; rsp data/zero 0; alu_* outputs 0; last_grant = 1, so port 0 wins the first tie.
- Acceptance is allowed in IDLE and in RESP only.
- Grant (combinational) when acceptance is allowed:
  - Only one port valid: that port is granted.
  - Both valid, RR_EN=1: grant the port != last_grant.
  - Both valid, RR_EN=0: grant port 0.
- reqN_ready = grant to port N. Handshake completes on reqN_valid & reqN_ready.
- On handshake:
  - Latch op, a, b, shamt and the granted port id into holding registers.
  - Update last_grant.
  - Next state = ISSUE.
- In RESP with no handshake, next state = IDLE.
- ISSUE, one cycle:
  - alu_* driven from the holding registers; the ALU samples them at the end of this cycle.
  - Next state = RESP.
- In every state other than ISSUE, alu_* hold their last values, so the ALU continues to see stable inputs.
- RESP, one cycle:
  - rspN_valid = 1 for the held port id only; the other port's rsp_valid = 0.
  - rspN_data = alu_out, except held op == 6 (branch compare), where data is forced to 0.
  - rspN_zero = alu_zero.
  - rsp_data/rsp_zero of the non-selected port hold 0.
- Latency: handshake in cycle N -> rsp_valid in cycle N+2. Sustained throughput: one op per 2 cycles when requests are back-to-back, because a new accept may happen in the RESP cycle.
- No response backpressure: a requester must sample the result in the RESP cycle.
- Requester rules: must hold valid and payload stable until ready. The arbiter never retracts ready within a cycle.
- Each port has at most one outstanding op, guaranteed by construction.
- Simultaneous rsp to one port and accept from the other in RESP is legal; both happen in the same cycle.
- Reset asserted mid-operation (ISSUE or RESP):
  - State goes to IDLE immediately; the in-flight op is dropped and no response is issued.
  - Outputs return to their reset values asynchronously.
- Operands pass through unmodified. Width rules are those of the ALU: add/sub wrap modulo 2^WIDTH, shifts use shamt only, SLT result is zero-extended.

Test Plan:
- Reset: assert rst_n=0 mid-ISSUE -> busy=0, all rsp_valid=0, alu_* = 0 immediately; no response after release.
- Single op: port 0 op=0, a=5, b=7 accepted in cycle N -> rsp0_valid in N+2, rsp0_data=12, rsp0_zero=0; rsp1_valid stays 0.
- Tie, RR_EN=1: both valid continuously, port 0 op=1 a=10 b=3, port 1 op=4 a=1 shamt=4 -> grants alternate 0,1,0,1 starting with port 0; responses 7 and 16 every 2 cycles.
- Tie, RR_EN=0: both valid continuously -> port 1 never granted while port 0 stays valid; port 1 is served in the first accept cycle after port 0 drops valid.
- Branch op: port 1 op=6, a=b=0x1234 -> rsp1_data=0, rsp1_zero=1; repeat with b=0x1235 -> rsp1_zero=0.
- Wrap and SLT: op=0 a=0xFFFFFFFF b=1 -> rsp_data=0; op=7 a=2 b=9 -> rsp_data=1.
